// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper and its test environment.
// Optional first-failure fields exist only when SWEEP_FIRST_FAIL_EN is defined.
interface truth_table_sweeper_if;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic [3:0]  abcd;
  logic        q;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [4:0]  mismatch_cnt;
  logic        pass;
`ifdef SWEEP_FIRST_FAIL_EN
  logic [3:0]  first_fail;
  logic        first_fail_vld;
`endif

  // master: environment that requests sweeps and hosts the circuit under test
  modport master (
    output start, abort, expected, q,
    input  abcd, busy, done, table_out, mismatch_cnt, pass
`ifdef SWEEP_FIRST_FAIL_EN
    , input first_fail, first_fail_vld
`endif
  );

  modport slave (
    input  start, abort, expected, q,
    output abcd, busy, done, table_out, mismatch_cnt, pass
`ifdef SWEEP_FIRST_FAIL_EN
    , output first_fail, first_fail_vld
`endif
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks a 4-input circuit through all 16 vectors, captures its truth table and
// counts mismatches against a golden table. SWEEP_FIRST_FAIL_EN adds first-failure capture.
module truth_table_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input logic                  clk,
  input logic                  areset_n,
  truth_table_sweeper_if.slave bus
);

  localparam int unsigned VEC_W  = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned TBL_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [VEC_W-1:0]   abcd_r;
  logic [HOLD_W-1:0]  hold_r;
  logic [TBL_W-1:0]   exp_r;
  logic [TBL_W-1:0]   table_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;
  logic               pass_r;
`ifdef SWEEP_FIRST_FAIL_EN
  logic [VEC_W-1:0]   ff_r;
  logic               ff_vld_r;
`endif

  logic               sample_c;
  logic               fail_c;
  logic [CNT_W-1:0]   cnt_nxt_c;

  // Sample on the edge that closes the last settle cycle of the current vector
  assign sample_c  = (state == RUN) && (hold_r == HOLD_W'(SETTLE));
  assign fail_c    = (bus.q != exp_r[abcd_r]);
  assign cnt_nxt_c = (fail_c && (cnt_r != CNT_W'(16))) ? cnt_r + CNT_W'(1) : cnt_r;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state    <= IDLE;
      abcd_r   <= '0;
      hold_r   <= '0;
      exp_r    <= '0;
      table_r  <= '0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
`ifdef SWEEP_FIRST_FAIL_EN
      ff_r     <= '0;
      ff_vld_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            abcd_r   <= '0;
            hold_r   <= '0;
            exp_r    <= bus.expected;
            table_r  <= '0;
            cnt_r    <= '0;
            pass_r   <= 1'b0;
            busy_r   <= 1'b1;
`ifdef SWEEP_FIRST_FAIL_EN
            ff_r     <= '0;
            ff_vld_r <= 1'b0;
`endif
          end
        end
        RUN: begin
          // Abort wins over a coincident sample; that sample is dropped
          if (bus.abort) begin
            state    <= IDLE;
            abcd_r   <= '0;
            hold_r   <= '0;
            pass_r   <= 1'b0;
            busy_r   <= 1'b0;
`ifdef SWEEP_FIRST_FAIL_EN
            ff_r     <= '0;
            ff_vld_r <= 1'b0;
`endif
          end else if (sample_c) begin
            table_r[abcd_r] <= bus.q;
            cnt_r           <= cnt_nxt_c;
            hold_r          <= '0;
`ifdef SWEEP_FIRST_FAIL_EN
            if (fail_c && !ff_vld_r) begin
              ff_r     <= abcd_r;
              ff_vld_r <= 1'b1;
            end
`endif
            if (abcd_r == VEC_W'(15)) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              pass_r <= (cnt_nxt_c == '0);
            end else begin
              abcd_r <= abcd_r + VEC_W'(1);
            end
          end else begin
            hold_r <= hold_r + HOLD_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.abcd         = abcd_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.table_out    = table_r;
  assign bus.mismatch_cnt = cnt_r;
  assign bus.pass         = pass_r;
`ifdef SWEEP_FIRST_FAIL_EN
  assign bus.first_fail     = ff_r;
  assign bus.first_fail_vld = ff_vld_r;
`endif

endmodule
